// File: rtl/apple2e_timing_decoder.sv
// Timing-bus receiver for the Apple IIe motherboard clocks.
// The 14M/7M/Q3/PHI0 lines are sampled as data in the clk_core domain.
// A snapshot of 7M/Q3/PHI0 is taken a fixed delay after each 14M rise.
// From those snapshots the block derives edge strobes, the phase within each
// 6502 cycle, the 65-cycle line position and the lock state.
module apple2e_timing_decoder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SAMPLE_DLY  = 1,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic       clk_core,
  input  logic       reset,
  input  logic       clk_14M,
  input  logic       clk_7M,
  input  logic       clk_q3,
  input  logic       clk_phi_0,
  output logic       tick_14M,
  output logic [3:0] phase,
  output logic       phi0_rise,
  output logic       phi0_fall,
  output logic       q3_rise,
  output logic [6:0] cycle_index,
  output logic       long_done,
  output logic       locked,
  output logic       timing_error
);

  localparam logic [1:0] ST_UNLOCKED  = 2'd0;
  localparam logic [1:0] ST_ACQUIRE   = 2'd1;
  localparam logic [1:0] ST_SEEK_LONG = 2'd2;
  localparam logic [1:0] ST_LOCKED    = 2'd3;

  localparam logic [4:0] LOCK_TGT = 5'(LOCK_CYCLES);

  logic [SYNC_STAGES-1:0] sync_14m;
  logic [SYNC_STAGES-1:0] sync_7m;
  logic [SYNC_STAGES-1:0] sync_q3;
  logic [SYNC_STAGES-1:0] sync_phi0;

  logic s14, s7, sq3, sphi;
  logic s14_prev;
  logic rise_det;
  logic snap_en;

  logic prev_7, prev_q3, prev_phi0;
  logic [1:0] state, next_state;
  logic [3:0] good_cnt, next_good;
  logic [6:0] seek_cnt, next_seek;

  logic       rise_e, fall_e, q3_e;
  logic [4:0] period_len;
  logic       is_long, is_short, valid_rise;
  logic       err_7m, err_period, err_long, any_err;
  logic [3:0] next_phase;
  logic [6:0] next_index;

  // Synchronizer chains, identical for all four timing lines
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      sync_14m  <= '0;
      sync_7m   <= '0;
      sync_q3   <= '0;
      sync_phi0 <= '0;
    end else begin
      sync_14m[0]  <= clk_14M;
      sync_7m[0]   <= clk_7M;
      sync_q3[0]   <= clk_q3;
      sync_phi0[0] <= clk_phi_0;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_14m[i]  <= sync_14m[i-1];
        sync_7m[i]   <= sync_7m[i-1];
        sync_q3[i]   <= sync_q3[i-1];
        sync_phi0[i] <= sync_phi0[i-1];
      end
    end
  end

  assign s14  = sync_14m[SYNC_STAGES-1];
  assign s7   = sync_7m[SYNC_STAGES-1];
  assign sq3  = sync_q3[SYNC_STAGES-1];
  assign sphi = sync_phi0[SYNC_STAGES-1];

  // Previous synced 14M level for rise detection
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) s14_prev <= 1'b0;
    else       s14_prev <= s14;
  end

  assign rise_det = s14 & ~s14_prev;

  // Delay from 14M rise detection to the snapshot cycle
  if (SAMPLE_DLY == 0) begin : g_no_dly
    assign snap_en = rise_det;
  end else begin : g_dly
    logic [SAMPLE_DLY-1:0] dly;
    // Shift the rise pulse by SAMPLE_DLY core cycles
    always_ff @(posedge clk_core or posedge reset) begin
      if (reset) begin
        dly <= '0;
      end else begin
        dly[0] <= rise_det;
        for (int unsigned i = 1; i < SAMPLE_DLY; i++) dly[i] <= dly[i-1];
      end
    end
    assign snap_en = dly[SAMPLE_DLY-1];
  end

  // Per-snapshot evaluation: edges, period checks, counters and lock FSM
  always_comb begin
    rise_e     = sphi & ~prev_phi0;
    fall_e     = ~sphi & prev_phi0;
    q3_e       = sq3 & ~prev_q3;
    period_len = {1'b0, phase} + 5'd1;
    is_long    = (period_len == 5'd16);
    is_short   = (period_len == 5'd14);
    valid_rise = rise_e & (is_long | is_short);
    err_7m     = (s7 == prev_7);
    err_period = rise_e & ~valid_rise;
    err_long   = 1'b0;
    next_state = state;
    next_good  = good_cnt;
    next_seek  = seek_cnt;

    if (rise_e)               next_phase = '0;
    else if (phase != 4'hF)   next_phase = phase + 4'd1;
    else                      next_phase = phase;

    next_index = cycle_index;
    if (valid_rise) begin
      if (is_long)                    next_index = '0;
      else if (cycle_index != 7'd64)  next_index = cycle_index + 7'd1;
    end

    if (valid_rise) begin
      case (state)
        ST_UNLOCKED: begin
          next_good  = 4'd1;
          next_seek  = '0;
          next_state = (LOCK_TGT <= 5'd1) ? ST_SEEK_LONG : ST_ACQUIRE;
        end
        ST_ACQUIRE: begin
          next_good = good_cnt + 4'd1;
          if (({1'b0, good_cnt} + 5'd1) >= LOCK_TGT) begin
            next_state = ST_SEEK_LONG;
            next_seek  = '0;
          end
        end
        ST_SEEK_LONG: begin
          if (is_long)                 next_state = ST_LOCKED;
          else if (seek_cnt == 7'd64)  err_long   = 1'b1;
          else                         next_seek  = seek_cnt + 7'd1;
        end
        ST_LOCKED: begin
          // The long cycle must land exactly on index 64, and only there.
          if (is_long != (cycle_index == 7'd64)) err_long = 1'b1;
        end
        default: next_state = ST_UNLOCKED;
      endcase
    end

    any_err = err_7m | err_period | err_long;
    if (any_err) begin
      next_state = ST_UNLOCKED;
      next_good  = '0;
      next_seek  = '0;
    end
  end

  // Registered strobes and state, updated only on snapshot cycles
  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      tick_14M     <= 1'b0;
      phi0_rise    <= 1'b0;
      phi0_fall    <= 1'b0;
      q3_rise      <= 1'b0;
      long_done    <= 1'b0;
      timing_error <= 1'b0;
      phase        <= '0;
      cycle_index  <= '0;
      prev_7       <= 1'b0;
      prev_q3      <= 1'b0;
      prev_phi0    <= 1'b0;
      state        <= ST_UNLOCKED;
      good_cnt     <= '0;
      seek_cnt     <= '0;
    end else begin
      tick_14M     <= snap_en;
      phi0_rise    <= 1'b0;
      phi0_fall    <= 1'b0;
      q3_rise      <= 1'b0;
      long_done    <= 1'b0;
      timing_error <= 1'b0;
      if (snap_en) begin
        prev_7       <= s7;
        prev_q3      <= sq3;
        prev_phi0    <= sphi;
        phi0_rise    <= rise_e;
        phi0_fall    <= fall_e;
        q3_rise      <= q3_e;
        long_done    <= valid_rise & is_long;
        timing_error <= any_err;
        phase        <= next_phase;
        cycle_index  <= next_index;
        state        <= next_state;
        good_cnt     <= next_good;
        seek_cnt     <= next_seek;
      end
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_apple2e_timing_decoder.sv
// Bench for apple2e_timing_decoder: PAL-like timing waveform with randomized
// core-clock spacing and injected faults, checked against a tick-level model.
module tb_apple2e_timing_decoder;

  localparam int unsigned LOCK_CYCLES = 4;

  logic       clk_core = 1'b0;
  logic       reset;
  logic       clk_14M, clk_7M, clk_q3, clk_phi_0;
  logic       tick_14M;
  logic [3:0] phase;
  logic       phi0_rise, phi0_fall, q3_rise;
  logic [6:0] cycle_index;
  logic       long_done, locked, timing_error;

  apple2e_timing_decoder #(
    .SYNC_STAGES (2),
    .SAMPLE_DLY  (1),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) dut (
    .clk_core     (clk_core),
    .reset        (reset),
    .clk_14M      (clk_14M),
    .clk_7M       (clk_7M),
    .clk_q3       (clk_q3),
    .clk_phi_0    (clk_phi_0),
    .tick_14M     (tick_14M),
    .phase        (phase),
    .phi0_rise    (phi0_rise),
    .phi0_fall    (phi0_fall),
    .q3_rise      (q3_rise),
    .cycle_index  (cycle_index),
    .long_done    (long_done),
    .locked       (locked),
    .timing_error (timing_error)
  );

  always #5 clk_core = ~clk_core;

  int checks = 0;
  int errors = 0;

  // Reference model state, in plain counts of ticks and periods
  bit m_p7, m_pq, m_pphi;
  bit m_locked;
  int m_phase, m_index;
  int m_nvalid;   // valid PHI0 periods seen since the last error/reset
  int m_shorts;   // short periods seen while searching for the long cycle

  // Waveform generator state
  bit g7;
  int pos;        // short cycles emitted since the last long cycle

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_p7 = 0; m_pq = 0; m_pphi = 0;
    m_locked = 0; m_phase = 0; m_index = 0; m_nvalid = 0; m_shorts = 0;
  endtask

  // Advance the model by one 14M tick and compare every output
  task automatic model_step(input bit v7, input bit vq, input bit vphi);
    bit r, f, qr, err, valid, seeking, ld;
    int len;
    r   = vphi && !m_pphi;
    f   = !vphi && m_pphi;
    qr  = vq && !m_pq;
    len = m_phase + 1;
    valid = r && (len == 14 || len == 16);
    err = (v7 == m_p7) || (r && !valid);
    seeking = !m_locked && (m_nvalid >= LOCK_CYCLES);
    if (valid) begin
      if (m_locked && ((len == 16) != (m_index == 64))) err = 1;
      if (seeking && len == 14 && m_shorts == 64) err = 1;
    end
    ld = valid && len == 16;
    if (valid) m_index = (len == 16) ? 0 : ((m_index + 1 > 64) ? 64 : m_index + 1);
    m_phase = r ? 0 : ((m_phase + 1 > 15) ? 15 : m_phase + 1);
    if (err) begin
      m_nvalid = 0; m_locked = 0; m_shorts = 0;
    end else if (valid) begin
      if (seeking && len == 16) m_locked = 1;
      else if (seeking) m_shorts++;
      m_nvalid++;
    end
    m_p7 = v7; m_pq = vq; m_pphi = vphi;
    chk("tick_14M", tick_14M, 1);
    chk("phi0_rise", phi0_rise, r);
    chk("phi0_fall", phi0_fall, f);
    chk("q3_rise", q3_rise, qr);
    chk("phase", phase, m_phase);
    chk("cycle_index", cycle_index, m_index);
    chk("long_done", long_done, ld);
    chk("locked", locked, m_locked);
    chk("timing_error", timing_error, err);
  endtask

  // One 14M period of 6..8 core cycles; snapshot expected 4 cycles after the rise
  task automatic drive_tick(input bit v7, input bit vq, input bit vphi);
    int unsigned n;
    n = $urandom_range(8, 6);
    @(negedge clk_core);
    clk_14M = 1; clk_7M = v7; clk_q3 = vq; clk_phi_0 = vphi;
    for (int unsigned j = 1; j < n; j++) begin
      @(negedge clk_core);
      if (j == n / 2) clk_14M = 0;
      if (j == 4) begin
        model_step(v7, vq, vphi);
      end else begin
        chk("tick_quiet", tick_14M, 0);
        chk("err_quiet", timing_error, 0);
      end
    end
  endtask

  // One PHI0 cycle of len ticks; optional 7M forced high for hold7 ticks from tick 2
  task automatic run_cycle(input int len, input int hold7);
    bit v7;
    for (int t = 0; t < len; t++) begin
      if (hold7 > 0 && t >= 2 && t < 2 + hold7) v7 = 1;
      else v7 = ~g7;
      g7 = v7;
      drive_tick(v7, (t < 14) && ((t % 7) < 4), t < 7);
    end
    if (len == 16) pos = 0;
    else pos++;
  endtask

  task automatic run_shorts(input int n);
    for (int i = 0; i < n; i++) run_cycle(14, 0);
  endtask

  task automatic run_to_long();
    run_shorts(64 - pos);
    run_cycle(16, 0);
  endtask

  // Lines held static: no strobes, no errors, state unchanged
  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_core);
      chk("idle_tick", tick_14M, 0);
      chk("idle_err", timing_error, 0);
      chk("idle_locked", locked, m_locked);
      chk("idle_phase", phase, m_phase);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_core);
    reset = 1;
    #1;
    chk("rst_tick", tick_14M, 0);
    chk("rst_phase", phase, 0);
    chk("rst_rise", phi0_rise, 0);
    chk("rst_fall", phi0_fall, 0);
    chk("rst_q3", q3_rise, 0);
    chk("rst_index", cycle_index, 0);
    chk("rst_long", long_done, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", timing_error, 0);
    model_reset();
    repeat (2) @(negedge clk_core);
    reset = 0;
  endtask

  initial begin
    reset = 1; clk_14M = 0; clk_7M = 0; clk_q3 = 0; clk_phi_0 = 0;
    g7 = 0; pos = 0;
    model_reset();
    repeat (2) @(negedge clk_core);
    do_reset();

    // Stuck timing lines after reset
    clk_7M = 1; clk_q3 = 1; clk_phi_0 = 1;
    idle(30);
    clk_7M = 0; clk_q3 = 0; clk_phi_0 = 0;

    // Ideal waveform from a random point in the line, then lock
    pos = 64 - $urandom_range(10, 0);
    run_to_long();
    run_shorts(64);
    run_cycle(16, 0);
    run_shorts(3);
    chk("s1_locked", locked, 1);
    idle(60);
    chk("idle_keeps_lock", locked, 1);

    // One 15-tick period, then reacquire
    run_shorts(3);
    run_cycle(15, 0);
    run_to_long();
    run_shorts(3);
    chk("s2_relocked", locked, 1);

    // 7M held high for 3 ticks, then reacquire
    run_shorts(2);
    run_cycle(14, 3);
    run_to_long();
    run_shorts(3);
    chk("s3_relocked", locked, 1);

    // Long cycle at index 30, relock, then an extra short at index 64
    run_shorts(30 - pos);
    run_cycle(16, 0);
    run_to_long();
    run_shorts(3);
    chk("s4_relocked", locked, 1);
    run_shorts(61);
    run_cycle(14, 0);
    run_shorts(2);
    chk("s4_short64_unlocked", locked, 0);
    run_shorts(4);
    run_cycle(16, 0);
    run_shorts(3);
    chk("s4_relocked2", locked, 1);

    // Reset mid-lock, then reacquire
    do_reset();
    run_shorts(5);
    run_to_long();
    run_shorts(3);
    chk("s5_relocked", locked, 1);

    // Random period lengths and 7M glitches
    for (int i = 0; i < 30; i++) begin
      int sel;
      sel = $urandom_range(5, 0);
      run_cycle((sel == 0) ? 13 : (sel == 1) ? 15 : (sel == 2) ? 16 : 14,
                ($urandom_range(7, 0) == 0) ? 2 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apple2e_timing_decoder.md
Name: apple2e_timing_decoder

Overview:
- Receiving end of the motherboard timing bus driven by AppleIIePAL (clk_14M, clk_7M, clk_q3, clk_phi_0).
- Samples the four timing lines as data in the fast clk_core domain and recovers the 14M tick, the phase position within each 6502 cycle, and the 65-cycle horizontal pattern (64 short cycles plus one long cycle).
- Outputs single-cycle strobes and lock status for the DRAM, video and bus-sequencing logic.

Parameters:
- SYNC_STAGES, 2: synchronizer flops per timing input (min 2).
- SAMPLE_DLY, 1: core cycles between 14M rise detection and the snapshot of 7M/Q3/PHI0 (0..3).
- LOCK_CYCLES, 4: consecutive valid PHI0 periods required before long-cycle search (1..15).

Ports:
- clk_core  in  1  core clock; frequency must be at least 4x 14.318 MHz.
- reset  in  1  asynchronous, active-high.
- clk_14M  in  1  14M timing line, sampled as data.
- clk_7M  in  1  7M timing line, sampled as data.
- clk_q3  in  1  Q3 timing line, sampled as data.
- clk_phi_0  in  1  PHI0 timing line, sampled as data.
- tick_14M  out  1  strobe on the snapshot cycle following each 14M rise.
- phase  out  4  14M ticks since the last PHI0 rise; saturates at 15.
- phi0_rise  out  1  strobe.
- phi0_fall  out  1  strobe.
- q3_rise  out  1  strobe.
- cycle_index  out  7  0..64 position in the 65-cycle line; 64 is the long cycle.
- long_done  out  1  strobe with phi0_rise when the completed cycle was 16 ticks.
- locked  out  1  high only in the LOCKED state.
- timing_error  out  1  single-cycle pulse.

Behaviour:
- Reset: all outputs 0, all synchronizers 0, previous-snapshot regs 0, state UNLOCKED.
- Synchronization: all four inputs pass through identical SYNC_STAGES chains.
- 14M rise: detected when the synced 14M is 1 and was 0 on the previous core cycle.
- Snapshot: taken SAMPLE_DLY cycles after the 14M rise is detected; tick_14M pulses on that cycle.
- Latency: input edge to tick_14M = SYNC_STAGES+1+SAMPLE_DLY core cycles.
- Edge strobes: phi0_rise, phi0_fall and q3_rise are computed only on snapshot cycles, from the current vs previous snapshot, and pulse coincident with tick_14M.
- Phase, on each snapshot:
  - On phi0_rise: period L = phase+1, then phase <= 0.
  - Otherwise: phase <= min(phase+1, 15).
- 7M check: the 7M snapshot must differ from the previous 7M snapshot on every tick. A repeated value raises error E7.
- Period check on phi0_rise: L must be 14 or 16; any other value raises error EP.
- cycle_index, on phi0_rise with a valid L:
  - L=16: index <= 0 and long_done pulses.
  - L=14: index <= index+1, saturating at 64.
- FSM (advances only on phi0_rise unless an error occurs):
  - UNLOCKED: on a valid phi0_rise, go to ACQUIRE with good count = 1.
  - ACQUIRE: count valid periods; at LOCK_CYCLES, go to SEEK_LONG.
  - SEEK_LONG: on L=16, go to LOCKED with index 0. If 65 valid short periods pass with no long cycle, raise error EL.
  - LOCKED: a short period arriving when index is 64, or a long period arriving when index is not 64, raises error EL.
- Error handling:
  - Any error (E7, EP, EL) pulses timing_error for one core cycle and forces state UNLOCKED. phase and index keep counting.
  - Errors are also reported while already UNLOCKED. The state stays UNLOCKED; a valid phi0_rise on that same snapshot does not advance it.
- Simultaneous events: if E7 and a valid phi0_rise occur on the same snapshot, the error wins.
- Reset mid-operation: returns immediately to reset values, and lock must be fully reacquired.
- Idle inputs: stuck lines produce no tick_14M strobes and no errors; state is held.

Test Plan:
- Ideal PAL waveform (PHI0 7H/7L, with every 65th cycle 16 ticks), LOCK_CYCLES=4 -> locked asserts on the first long cycle after 4 valid periods. long_done fires every 65 phi0_rise. phase runs 0..13 (0..15 in the long cycle). No timing_error.
- Locked, then one PHI0 period of 15 ticks -> one timing_error pulse, locked=0, reacquisition to locked by the next long cycle after 4 good periods.
- Locked, then clk_7M held high for 3 ticks -> timing_error on the first repeated snapshot, locked=0.
- Locked, then a long cycle injected at index 30 -> timing_error, UNLOCKED. A short cycle at index 64 likewise -> timing_error.
- Assert reset for 2 core cycles mid-lock -> all outputs 0 asynchronously, and reacquisition completes as in scenario 1.
- Latency check, SYNC_STAGES=2, SAMPLE_DLY=1: tick_14M asserts exactly 4 core cycles after the clk_14M input rises, and q3_rise coincides with the tick at which the Q3 snapshot first reads 1.
